convolutor_3x3: RTL and testbench

Streaming 3×3 window engine for the U-Net datapath. It consumes one signed 8-bit pixel per clock in raster order, keeps two runtime-width line buffers, and forms a zero-padded 3×3 neighbourhood for each pixel. Its main use is a signed multiply-accumulate with a 32-bit bias and optional ReLU. It sits between the layer feature-map buffer and the quantisation/store stage.

---
 rtl/unet_pkg.sv | 34 +++
 rtl/conv_line_buffer.sv | 52 +++++
 rtl/convolutor_3x3.sv | 176 +++++++++++++++++
 tb/tb_convolutor_3x3.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/unet_pkg.sv
// ---------------------------------------------------------------------------
// unet_pkg -- shared definitions for the U-Net datapath blocks.
//
// Contents:
//   PIX_W / PROD_W / ACC_W : pixel, product and accumulator widths
//   op_e                   : operation codes of the 3x3 window engine
//   clamp_width()          : limits a runtime row length to 3..max_w
// ---------------------------------------------------------------------------
package unet_pkg;

   localparam int PIX_W  = 8;
   localparam int PROD_W = 2 * PIX_W;
   localparam int ACC_W  = 32;

   typedef enum logic [1:0] {
      OP_CONV     = 2'd0,
      OP_MAXPOOL2 = 2'd1,
      OP_PASS     = 2'd2,
      OP_RSVD     = 2'd3
   } op_e;

   // Row length actually used by the line buffers. The 3x3 window needs at
   // least three columns, and the buffers cannot be longer than max_w.
   function automatic logic [7:0] clamp_width(input logic [7:0] w, input int max_w);
      if (int'(w) > max_w) begin
         return 8'(max_w);
      end else if (w < 8'd3) begin
         return 8'd3;
      end else begin
         return w;
      end
   endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// ---------------------------------------------------------------------------
// conv_line_buffer -- variable-length signed delay line.
//
// Shifts din in on every rising clk edge (no enable). dout is the entry that
// went in exactly `tap` edges ago, so with tap = W it is the pixel one row
// above the current input. Entries clear asynchronously while rst_n is low.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low clear
//   din    in   PIX_W  signed sample shifted in each edge
//   tap    in   8      delay in edges, 1..DEPTH
//   dout   out  PIX_W  delayed sample (combinational tap select)
// ---------------------------------------------------------------------------
module conv_line_buffer
   import unet_pkg::*;
#(
   parameter int DEPTH = 128
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [PIX_W-1:0] din,
   input  logic        [7:0]       tap,
   output logic signed [PIX_W-1:0] dout
);

   logic signed [PIX_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         mem[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            mem[i] <= mem[i-1];
         end
      end
   end

   // mem[i] holds the sample shifted in i+1 edges ago.
   always_comb begin
      dout = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (int'(tap) == i + 1) begin
            dout = mem[i];
         end
      end
   end

endmodule

// File: rtl/convolutor_3x3.sv
// ---------------------------------------------------------------------------
// convolutor_3x3 -- streaming 3x3 window engine.
//
// Takes one signed pixel per clock in raster order and forms the 3x3
// neighbourhood centred on pixel m = q-W-1, where q is the pixel currently
// on pixel_in. The result for m is combinational and is valid at the edge
// that shifts q in. Operations: CONV (MAC + bias), MAXPOOL2, PASS, reserved.
// ReLU is applied after every operation. Side borders are zeroed by the
// source through paddingl / paddingr; top border comes from the reset clear,
// bottom border from W+1 trailing zero pixels.
//
// Build option:
//   CONVOLUTOR3X3_MAXPOOL_EN  defined   -> operation 1 is a 2x2 max pool
//                             undefined -> operation 1 outputs 0 (reserved)
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset, also the per-frame clear
//   pixel_in   in   8   signed pixel q
//   w1..w9     in   8   signed weights, rows top..bottom, left..right
//   bias       in   32  signed bias (CONV only)
//   operation  in   2   0 CONV, 1 MAXPOOL2, 2 PASS, 3 reserved
//   width      in   8   active row length, clamped to 3..IMAGE_WIDTH
//   paddingl   in   1   zero taps w3, w6, w9 (centre in last column)
//   paddingr   in   1   zero taps w1, w4, w7 (centre in first column)
//   relu       in   1   clamp negative results to 0
//   pixel_out  out  32  signed result, forced to 0 while in reset
// ---------------------------------------------------------------------------
module convolutor_3x3
   import unet_pkg::*;
#(
   parameter int IMAGE_WIDTH  = 128,
   parameter int IMAGE_HEIGHT = 128
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [PIX_W-1:0] pixel_in,
   input  logic signed [PIX_W-1:0] w1,
   input  logic signed [PIX_W-1:0] w2,
   input  logic signed [PIX_W-1:0] w3,
   input  logic signed [PIX_W-1:0] w4,
   input  logic signed [PIX_W-1:0] w5,
   input  logic signed [PIX_W-1:0] w6,
   input  logic signed [PIX_W-1:0] w7,
   input  logic signed [PIX_W-1:0] w8,
   input  logic signed [PIX_W-1:0] w9,
   input  logic signed [ACC_W-1:0] bias,
   input  logic        [1:0]       operation,
   input  logic        [7:0]       width,
   input  logic                    paddingl,
   input  logic                    paddingr,
   input  logic                    relu,
   output logic signed [ACC_W-1:0] pixel_out
);

   // There is no row counter, so the frame height is informational only.
   logic unused_height;
   assign unused_height = ^32'(IMAGE_HEIGHT);

   logic [7:0] w_eff;
   assign w_eff = clamp_width(width, IMAGE_WIDTH);

   // Window storage. Names give the delay relative to q:
   //   bot_1 = q-1,   bot_2 = q-2
   //   mid_0 = q-W,   mid_1 = q-W-1,  mid_2 = q-W-2
   //   top_0 = q-2W,  top_1 = q-2W-1, top_2 = q-2W-2
   logic signed [PIX_W-1:0] bot_1, bot_2;
   logic signed [PIX_W-1:0] mid_0, mid_1, mid_2;
   logic signed [PIX_W-1:0] top_0, top_1, top_2;

   conv_line_buffer #(.DEPTH(IMAGE_WIDTH)) u_line_mid (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (pixel_in),
      .tap   (w_eff),
      .dout  (mid_0)
   );

   conv_line_buffer #(.DEPTH(IMAGE_WIDTH)) u_line_top (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (mid_0),
      .tap   (w_eff),
      .dout  (top_0)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bot_1 <= '0;
         bot_2 <= '0;
         mid_1 <= '0;
         mid_2 <= '0;
         top_1 <= '0;
         top_2 <= '0;
      end else begin
         bot_1 <= pixel_in;
         bot_2 <= bot_1;
         mid_1 <= mid_0;
         mid_2 <= mid_1;
         top_1 <= top_0;
         top_2 <= top_1;
      end
   end

   // Tap k pairs with weight w(k+1). Masks zero a whole window column when
   // the stream would otherwise wrap into the neighbouring row.
   logic signed [PIX_W-1:0]  tap  [9];
   logic signed [PIX_W-1:0]  wt   [9];
   logic signed [PROD_W-1:0] prod [9];
   logic signed [ACC_W-1:0]  acc;

   always_comb begin
      tap[0] = paddingr ? '0 : top_2;
      tap[1] = top_1;
      tap[2] = paddingl ? '0 : top_0;
      tap[3] = paddingr ? '0 : mid_2;
      tap[4] = mid_1;
      tap[5] = paddingl ? '0 : mid_0;
      tap[6] = paddingr ? '0 : bot_2;
      tap[7] = bot_1;
      tap[8] = paddingl ? '0 : pixel_in;
   end

   always_comb begin
      wt[0] = w1;
      wt[1] = w2;
      wt[2] = w3;
      wt[3] = w4;
      wt[4] = w5;
      wt[5] = w6;
      wt[6] = w7;
      wt[7] = w8;
      wt[8] = w9;
   end

   // 8x8 signed products fit exactly in 16 bits; the 32-bit sum wraps.
   always_comb begin
      acc = bias;
      for (int i = 0; i < 9; i++) begin
         prod[i] = PROD_W'(tap[i]) * PROD_W'(wt[i]);
         acc     = acc + ACC_W'(prod[i]);
      end
   end

`ifdef CONVOLUTOR3X3_MAXPOOL_EN
   // 2x2 block whose top-left is the window centre; padding does not apply.
   logic signed [PIX_W-1:0] pool_max;

   always_comb begin
      pool_max = pixel_in;
      if (bot_1 > pool_max) pool_max = bot_1;
      if (mid_0 > pool_max) pool_max = mid_0;
      if (mid_1 > pool_max) pool_max = mid_1;
   end
`endif

   logic signed [ACC_W-1:0] result;

   always_comb begin
      result = '0;
      case (op_e'(operation))
         OP_CONV:     result = acc;
`ifdef CONVOLUTOR3X3_MAXPOOL_EN
         OP_MAXPOOL2: result = ACC_W'(pool_max);
`endif
         OP_PASS:     result = ACC_W'(mid_1);
         default:     result = '0;
      endcase
      if (relu && result[ACC_W-1]) begin
         result = '0;
      end
   end

   assign pixel_out = rst_n ? result : '0;

endmodule

// File: tb/tb_convolutor_3x3.sv
// ---------------------------------------------------------------------------
// tb_convolutor_3x3 -- self-checking bench for convolutor_3x3.
//
// Reference model works on the image as a 2-D array with zero borders (CONV,
// PASS) and on the raster stream for MAXPOOL2. Expected results go into a
// scoreboard queue in output order and are popped as pixel_out is sampled.
// ---------------------------------------------------------------------------
module tb_convolutor_3x3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic signed [7:0]  pixel_in = '0;
   logic signed [7:0]  w1, w2, w3, w4, w5, w6, w7, w8, w9;
   logic signed [31:0] bias;
   logic        [1:0]  operation;
   logic        [7:0]  width;
   logic               paddingl = 1'b0;
   logic               paddingr = 1'b0;
   logic               relu;
   logic signed [31:0] pixel_out;

   convolutor_3x3 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pixel_in  (pixel_in),
      .w1        (w1),
      .w2        (w2),
      .w3        (w3),
      .w4        (w4),
      .w5        (w5),
      .w6        (w6),
      .w7        (w7),
      .w8        (w8),
      .w9        (w9),
      .bias      (bias),
      .operation (operation),
      .width     (width),
      .paddingl  (paddingl),
      .paddingr  (paddingr),
      .relu      (relu),
      .pixel_out (pixel_out)
   );

   // ---------------- configuration / model state ----------------
   int n_checks = 0;
   int n_pass   = 0;

   int img [0:7][0:127];
   int wt  [9];
   int bias_v;
   bit relu_v;
   int op_v;

   logic [31:0] exp_q[$];

   int plan_exp [16] = '{544, 22, 0, 3699, 14, 0, 100, 0, 1, 2, 0, 0, 36, 76, 0, 38};

   // ---------------- checker ----------------
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                  tag, $signed(got), got, $signed(exp), exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int pix2d(int r, int c, int wm, int hm);
      if (r < 0 || r >= hm || c < 0 || c >= wm) return 0;
      return img[r][c];
   endfunction

   function automatic int pix_s(int k, int wm, int hm);
      if (k < 0 || k >= wm * hm) return 0;
      return img[k / wm][k % wm];
   endfunction

   function automatic int model(int m, int wm, int hm);
      int r = m / wm;
      int c = m % wm;
      int v = 0;
      int q = m + wm + 1;
      case (op_v)
         0: begin
            v = bias_v;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++)
                  v += wt[(dr + 1) * 3 + dc + 1] * pix2d(r + dr, c + dc, wm, hm);
         end
         1: begin
`ifdef CONVOLUTOR3X3_MAXPOOL_EN
            v = pix_s(q, wm, hm);
            if (pix_s(q - 1, wm, hm) > v)      v = pix_s(q - 1, wm, hm);
            if (pix_s(q - wm, wm, hm) > v)     v = pix_s(q - wm, wm, hm);
            if (pix_s(q - wm - 1, wm, hm) > v) v = pix_s(q - wm - 1, wm, hm);
`else
            v = 0;
`endif
         end
         2: v = pix2d(r, c, wm, hm);
         default: v = 0;
      endcase
      if (relu_v && v < 0) v = 0;
      return v;
   endfunction

   task automatic fill_model(input int wm, input int hm);
      for (int m = 0; m < wm * hm; m++) exp_q.push_back(32'(model(m, wm, hm)));
   endtask

   // ---------------- drivers ----------------
   task automatic apply_cfg();
      w1 = 8'(wt[0]); w2 = 8'(wt[1]); w3 = 8'(wt[2]);
      w4 = 8'(wt[3]); w5 = 8'(wt[4]); w6 = 8'(wt[5]);
      w7 = 8'(wt[6]); w8 = 8'(wt[7]); w9 = 8'(wt[8]);
      bias      = bias_v;
      relu      = relu_v;
      operation = 2'(op_v);
   endtask

   // Reset with a configuration that would give a non-zero output if the
   // reset forcing were missing, then restore the frame configuration.
   task automatic do_reset();
      rst_n     = 1'b0;
      pixel_in  = 8'sd77;
      bias      = 32'sd12345;
      operation = 2'd0;
      relu      = 1'b0;
      #2;
      check_val("reset_out", pixel_out, 32'd0);
      @(posedge clk); #1;
      check_val("reset_hold", pixel_out, 32'd0);
      pixel_in = '0;
      apply_cfg();
      rst_n = 1'b1;
      #1;
   endtask

   // Streams the frame plus W+1 trailing zeros. Outputs are sampled on the
   // falling edge before the edge that consumes q. only_m >= 0 restricts
   // checking to one output pixel; limit stops the stream early.
   task automatic run_frame(input string tag, input int port_w, input int wm, input int hm,
                            input bit pad_r_en, input int only_m, input int limit);
      int total = hm * wm + wm + 1;
      width = 8'(port_w);
      for (int q = 0; q < total && q < limit; q++) begin
         pixel_in = 8'(pix_s(q, wm, hm));
         paddingr = pad_r_en && (q % wm == 1);
         paddingl = (q % wm == 0);
         @(negedge clk);
         if (q >= wm + 1 && (only_m < 0 || only_m == q - wm - 1)) begin
            check_val($sformatf("%s_m%0d", tag, q - wm - 1), pixel_out, exp_q.pop_front());
         end
         @(posedge clk); #1;
      end
      pixel_in = '0;
      paddingl = 1'b0;
      paddingr = 1'b0;
   endtask

   task automatic set_plan(input bit relu_b);
      wt     = '{0, 1, 0, -1, 39, -1, 0, 2, 0};
      bias_v = -1;
      relu_v = relu_b;
      op_v   = 0;
      for (int r = 0; r < 8; r++) for (int c = 0; c < 128; c++) img[r][c] = 0;
      img[0][0] = 14; img[0][1] = 1;  img[0][2] = 0; img[0][3] = 100;
      img[1][0] = 0;  img[1][1] = -1; img[1][2] = 0; img[1][3] = -100;
      img[3][0] = 1;  img[3][1] = 2;  img[3][2] = 0; img[3][3] = 1;
   endtask

   task automatic random_image(input int wm, input int hm);
      for (int r = 0; r < 8; r++) for (int c = 0; c < 128; c++) img[r][c] = 0;
      for (int r = 0; r < hm; r++)
         for (int c = 0; c < wm; c++)
            img[r][c] = int'($urandom_range(0, 255)) - 128;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      // Reset state: all taps zero, so CONV gives just the bias.
      set_plan(1'b0);
      apply_cfg();
      width = 8'd4;
      do_reset();
      check_val("post_reset_bias", pixel_out, 32'hFFFF_FFFF);

      // CONV full frame, ReLU on, against the listed values.
      set_plan(1'b1);
      do_reset();
      foreach (plan_exp[i]) exp_q.push_back(32'(plan_exp[i]));
      run_frame("conv_plan", 4, 4, 4, 1'b1, -1, 1000);

      // Same frame without ReLU.
      set_plan(1'b0);
      do_reset();
      fill_model(4, 4);
      check_val("relu_off_p5_model", exp_q[5], 32'hFFFF_FFD9);
      check_val("relu_off_p7_model", exp_q[7], -32'sd3801);
      run_frame("conv_norelu", 4, 4, 4, 1'b1, -1, 1000);

      // Left-column mask withheld: pixel 4 picks up pixel 3 (100 * -1).
      set_plan(1'b0);
      do_reset();
      exp_q.push_back(-32'sd86);
      run_frame("nomask_p4", 4, 4, 4, 1'b0, 4, 1000);

      // PASS: input delayed W+1, sign-extended.
      set_plan(1'b0);
      op_v = 2;
      do_reset();
      fill_model(4, 4);
      run_frame("pass", 4, 4, 4, 1'b1, -1, 1000);

      // Reset in the middle of a frame, then the full frame again.
      set_plan(1'b1);
      do_reset();
      foreach (plan_exp[i]) exp_q.push_back(32'(plan_exp[i]));
      run_frame("conv_abort", 4, 4, 4, 1'b1, -1, 8);
      exp_q.delete();
      do_reset();
      foreach (plan_exp[i]) exp_q.push_back(32'(plan_exp[i]));
      run_frame("conv_rerun", 4, 4, 4, 1'b1, -1, 1000);

      // Operation 1 on a 2x2 block {3,-5; 7,1}.
      set_plan(1'b0);
      op_v = 1;
      img[0][0] = 3; img[0][1] = -5; img[0][2] = 0; img[0][3] = 0;
      img[1][0] = 7; img[1][1] = 1;  img[1][2] = 0; img[1][3] = 0;
      do_reset();
`ifdef CONVOLUTOR3X3_MAXPOOL_EN
      exp_q.push_back(32'd7);
`else
      exp_q.push_back(32'd0);
`endif
      run_frame("pool_block", 4, 4, 2, 1'b1, 0, 1000);

      // Width clamping at both ends, in PASS mode.
      op_v = 2; relu_v = 1'b0; bias_v = 0;
      random_image(3, 3);
      do_reset();
      fill_model(3, 3);
      run_frame("clamp_lo", 1, 3, 3, 1'b1, -1, 1000);
      random_image(128, 2);
      do_reset();
      fill_model(128, 2);
      run_frame("clamp_hi", 255, 128, 2, 1'b1, -1, 1000);

      // Randomised frames over all operations.
      for (int t = 0; t < 10; t++) begin
         int wm = int'($urandom_range(3, 8));
         int hm = int'($urandom_range(2, 5));
         for (int i = 0; i < 9; i++) wt[i] = int'($urandom_range(0, 255)) - 128;
         bias_v = int'($urandom);
         if ($urandom_range(0, 1) == 1) bias_v = bias_v % 50000;
         relu_v = 1'($urandom_range(0, 1));
         op_v   = int'($urandom_range(0, 3));
         random_image(wm, hm);
         do_reset();
         fill_model(wm, hm);
         run_frame($sformatf("rand%0d_op%0d", t, op_v), wm, wm, hm, 1'b1, -1, 1000);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
